// File: rtl/branch_outcome_tracker_pkg.sv
// ----------------------------------------------------------------------------
// branch_outcome_tracker_pkg
//   Definitions shared by the branch outcome tracker and the 2-bit predictor:
//   default sizes, branch direction encoding and the occupancy width helper.
// ----------------------------------------------------------------------------
package branch_outcome_tracker_pkg;

    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        DIR_NOT_TAKEN = 1'b0,
        DIR_TAKEN     = 1'b1
    } dir_e;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_outcome_tracker_outcome_fifo.sv
// ----------------------------------------------------------------------------
// outcome_fifo
//   DEPTH x 1 synchronous FIFO holding predicted directions of outstanding
//   branches, oldest at the head.
// Ports
//   clk      in   clock, all updates on posedge
//   rst      in   asynchronous active-high reset, empties the FIFO
//   i_push   in   write i_din at the tail
//   i_din    in   predicted direction to store
//   i_pop    in   discard the head entry
//   i_clear  in   drop every entry (has priority over push/pop)
//   o_head   out  predicted direction of the oldest entry
//   o_count  out  number of valid entries
// ----------------------------------------------------------------------------
module outcome_fifo
    import branch_outcome_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_din,
    input  logic                      i_pop,
    input  logic                      i_clear,
    output logic                      o_head,
    output logic [occ_w(DEPTH)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + OCC_W'(i_push) - OCC_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/branch_outcome_tracker.sv
// ----------------------------------------------------------------------------
// branch_outcome_tracker
//   Queues each prediction of the 2-bit predictor in issue order, compares it
//   with the resolved direction, trains the predictor (result/taken), flags
//   mispredicts with a wrong-path flush and keeps saturating statistics.
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   issue           branch fetched (also the predictor request)
//   issue_ready     an issue can be accepted this cycle
//   pred            predictor output, valid one cycle after issue
//   resolve_valid   oldest outstanding branch resolved
//   resolve_taken   its actual direction
//   resolve_ready   resolve accepted on this edge
//   result, taken   training strobe / direction to the predictor
//   mispredict      1-cycle pulse when prediction != actual
//   flush           1-cycle pulse alongside mispredict
//   occupancy       valid queue entries
//   branch_cnt      resolved branches (saturating)
//   mispred_cnt     mispredicted branches (saturating)
//   overflow_err    sticky: issue while !issue_ready
//   underflow_err   sticky: resolve with nothing outstanding
// ----------------------------------------------------------------------------
module branch_outcome_tracker
    import branch_outcome_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    output logic                     issue_ready,
    input  logic                     pred,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     result,
    output logic                     taken,
    output logic                     mispredict,
    output logic                     flush,
    output logic [occ_w(DEPTH)-1:0]  occupancy,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int unsigned OCC_W = occ_w(DEPTH);

    logic             r_issue_d;
    logic             r_result;
    logic             r_taken;
    logic             r_mispredict;
    logic             r_overflow;
    logic             r_underflow;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [OCC_W-1:0] w_occ;
    logic             w_head;
    dir_e             w_head_dir;
    logic             w_issue_ready;
    logic             w_resolve_ready;
    logic             w_resolve_try;
    logic             w_occ_nz;
    logic             w_accept;
    logic             w_mispredict;

    // A pending issue_d already owns a slot, so it counts against capacity.
    assign w_issue_ready   = (w_occ + OCC_W'(r_issue_d)) < OCC_W'(DEPTH);
    // The predictor ignores result while request is high, so a new resolve
    // must wait until the held result has been consumed.
    assign w_resolve_ready = !(r_result && issue);
    assign w_resolve_try   = resolve_valid && w_resolve_ready;
    assign w_occ_nz        = (w_occ != '0);
    assign w_accept        = w_resolve_try && w_occ_nz;
    assign w_head_dir      = dir_e'(w_head);
    assign w_mispredict    = w_accept && (w_head_dir != dir_e'(resolve_taken));

    outcome_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_issue_d && !w_mispredict),
        .i_din   (pred),
        .i_pop   (w_accept && !w_mispredict),
        .i_clear (w_mispredict),
        .o_head  (w_head),
        .o_count (w_occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_d     <= 1'b0;
            r_result      <= 1'b0;
            r_taken       <= DIR_NOT_TAKEN;
            r_mispredict  <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            // A mispredict squashes the pending and the same-cycle issue as
            // wrong-path work; neither counts as an overflow.
            r_issue_d <= issue && w_issue_ready && !w_mispredict;
            if (issue && !w_issue_ready && !w_mispredict) begin
                r_overflow <= 1'b1;
            end
            if (w_resolve_try && !w_occ_nz) begin
                r_underflow <= 1'b1;
            end

            if (w_accept) begin
                r_result <= 1'b1;
                r_taken  <= resolve_taken;
            end else if (!issue) begin
                r_result <= 1'b0;
                r_taken  <= DIR_NOT_TAKEN;
            end

            r_mispredict <= w_mispredict;

            if (w_accept && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign issue_ready   = w_issue_ready;
    assign resolve_ready = w_resolve_ready;
    assign result        = r_result;
    assign taken         = r_taken;
    assign mispredict    = r_mispredict;
    assign flush         = r_mispredict;
    assign occupancy     = w_occ;
    assign branch_cnt    = r_branch_cnt;
    assign mispred_cnt   = r_mispred_cnt;
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
module tb_branch_outcome_tracker;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue, pred, resolve_valid, resolve_taken;
    logic             issue_ready, resolve_ready;
    logic             result, taken, mispredict, flush;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;
    logic             overflow_err, underflow_err;

    branch_outcome_tracker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue         (issue),
        .issue_ready   (issue_ready),
        .pred          (pred),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_ready (resolve_ready),
        .result        (result),
        .taken         (taken),
        .mispredict    (mispredict),
        .flush         (flush),
        .occupancy     (occupancy),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of outstanding predictions in program order.
    bit mq[$];
    bit m_pend, m_res, m_tk, m_mis, m_ovf, m_unf;
    int m_b, m_m;

    logic s_ir, s_rr;

    typedef struct {
        bit i, p, v, t;
        bit ir, rr;
        int occ;
        bit res, tk, mis;
        int b, m;
        bit ovf, unf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_res = 0; m_tk = 0; m_mis = 0; m_ovf = 0; m_unf = 0;
        m_b = 0; m_m = 0;
    endtask

    function automatic bit model_ir();
        return (mq.size() + int'(m_pend)) < DEPTH;
    endfunction

    function automatic bit model_rr();
        return !(m_res && issue);
    endfunction

    // Applies the rules of one clock edge to the model using current inputs.
    task automatic model_edge();
        bit ir, rr, tried, acc, mis, head;
        ir    = model_ir();
        rr    = model_rr();
        tried = resolve_valid && rr;
        acc   = tried && (mq.size() > 0);
        head  = acc ? mq[0] : 1'b0;
        mis   = acc && (head != resolve_taken);
        if (tried && mq.size() == 0) m_unf = 1;
        if (mis) begin
            mq.delete();
            m_pend = 0;
        end else begin
            if (acc) void'(mq.pop_front());
            if (m_pend) mq.push_back(pred);
            if (issue && !ir) m_ovf = 1;
            m_pend = issue && ir;
        end
        if (acc) begin
            m_res = 1;
            m_tk  = resolve_taken;
        end else if (!issue) begin
            m_res = 0;
            m_tk  = 0;
        end
        m_mis = mis;
        if (acc && m_b < CNT_MAX) m_b++;
        if (mis && m_m < CNT_MAX) m_m++;
    endtask

    task automatic check_model();
        chk("result",        32'(result),        32'(m_res));
        chk("taken",         32'(taken),         32'(m_tk));
        chk("mispredict",    32'(mispredict),    32'(m_mis));
        chk("flush",         32'(flush),         32'(m_mis));
        chk("occupancy",     32'(occupancy),     32'(mq.size()));
        chk("branch_cnt",    32'(branch_cnt),    32'(m_b));
        chk("mispred_cnt",   32'(mispred_cnt),   32'(m_m));
        chk("overflow_err",  32'(overflow_err),  32'(m_ovf));
        chk("underflow_err", 32'(underflow_err), 32'(m_unf));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_issue_ready"},   32'(issue_ready),   32'd1);
        chk({tag, "_resolve_ready"}, 32'(resolve_ready), 32'd1);
        chk({tag, "_result"},        32'(result),        32'd0);
        chk({tag, "_taken"},         32'(taken),         32'd0);
        chk({tag, "_mispredict"},    32'(mispredict),    32'd0);
        chk({tag, "_flush"},         32'(flush),         32'd0);
        chk({tag, "_occupancy"},     32'(occupancy),     32'd0);
        chk({tag, "_branch_cnt"},    32'(branch_cnt),    32'd0);
        chk({tag, "_mispred_cnt"},   32'(mispred_cnt),   32'd0);
        chk({tag, "_overflow_err"},  32'(overflow_err),  32'd0);
        chk({tag, "_underflow_err"}, 32'(underflow_err), 32'd0);
    endtask

    // One cycle: drive on negedge, check ready signals before the edge,
    // advance the model at the edge, check registered outputs after it.
    task automatic step(input bit i, input bit p, input bit v, input bit t);
        @(negedge clk);
        issue = i; pred = p; resolve_valid = v; resolve_taken = t;
        #1;
        s_ir = issue_ready;
        s_rr = resolve_ready;
        chk("issue_ready",   32'(s_ir), 32'(model_ir()));
        chk("resolve_ready", 32'(s_rr), 32'(model_rr()));
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic add(input bit i, p, v, t, ir, rr, input int occ,
                       input bit res, tk, mis, input int b, m, input bit ovf, unf);
        vec_t e;
        e = '{i:i, p:p, v:v, t:t, ir:ir, rr:rr, occ:occ, res:res, tk:tk, mis:mis,
              b:b, m:m, ovf:ovf, unf:unf};
        tbl.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // in: i p v t | pre-edge: ir rr | post-edge: occ res tk mis b m ovf unf
        // basic taken branch, correctly predicted
        add(1,0,0,0, 1,1, 0, 0,0,0, 0,0, 0,0);
        add(0,1,0,0, 1,1, 1, 0,0,0, 0,0, 0,0);
        add(0,0,1,1, 1,1, 0, 1,1,0, 1,0, 0,0);
        add(0,0,0,0, 1,1, 0, 0,0,0, 1,0, 0,0);
        // oldest predicted taken + 3 younger, resolves not-taken -> flush
        add(1,0,0,0, 1,1, 0, 0,0,0, 1,0, 0,0);
        add(1,1,0,0, 1,1, 1, 0,0,0, 1,0, 0,0);
        add(1,0,0,0, 1,1, 2, 0,0,0, 1,0, 0,0);
        add(1,0,0,0, 1,1, 3, 0,0,0, 1,0, 0,0);
        add(0,0,0,0, 0,1, 4, 0,0,0, 1,0, 0,0);
        add(0,0,1,0, 0,1, 0, 1,0,1, 2,1, 0,0);
        add(0,0,0,0, 1,1, 0, 0,0,0, 2,1, 0,0);
        // fill to DEPTH then over-issue
        add(1,1,0,0, 1,1, 0, 0,0,0, 2,1, 0,0);
        add(1,1,0,0, 1,1, 1, 0,0,0, 2,1, 0,0);
        add(1,1,0,0, 1,1, 2, 0,0,0, 2,1, 0,0);
        add(1,1,0,0, 1,1, 3, 0,0,0, 2,1, 0,0);
        add(1,1,0,0, 0,1, 4, 0,0,0, 2,1, 1,0);
        add(1,1,0,0, 0,1, 4, 0,0,0, 2,1, 1,0);
        add(0,0,0,0, 0,1, 4, 0,0,0, 2,1, 1,0);
        // drain, then resolve with an empty queue
        add(0,0,1,1, 0,1, 3, 1,1,0, 3,1, 1,0);
        add(0,0,1,1, 1,1, 2, 1,1,0, 4,1, 1,0);
        add(0,0,1,1, 1,1, 1, 1,1,0, 5,1, 1,0);
        add(0,0,1,1, 1,1, 0, 1,1,0, 6,1, 1,0);
        add(0,0,0,0, 1,1, 0, 0,0,0, 6,1, 1,0);
        add(0,0,1,1, 1,1, 0, 0,0,0, 6,1, 1,1);
        // result hold while issue stays high
        add(1,0,0,0, 1,1, 0, 0,0,0, 6,1, 1,1);
        add(0,0,0,0, 1,1, 1, 0,0,0, 6,1, 1,1);
        add(1,0,1,0, 1,1, 0, 1,0,0, 7,1, 1,1);
        add(1,1,1,1, 1,0, 1, 1,0,0, 7,1, 1,1);
        add(0,1,0,0, 1,1, 2, 0,0,0, 7,1, 1,1);

        rst = 1'b1; issue = 0; pred = 0; resolve_valid = 0; resolve_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i, tbl[k].p, tbl[k].v, tbl[k].t);
            chk($sformatf("t%0d_ir", k),   32'(s_ir),          32'(tbl[k].ir));
            chk($sformatf("t%0d_rr", k),   32'(s_rr),          32'(tbl[k].rr));
            chk($sformatf("t%0d_occ", k),  32'(occupancy),     32'(tbl[k].occ));
            chk($sformatf("t%0d_res", k),  32'(result),        32'(tbl[k].res));
            chk($sformatf("t%0d_tk", k),   32'(taken),         32'(tbl[k].tk));
            chk($sformatf("t%0d_mis", k),  32'(mispredict),    32'(tbl[k].mis));
            chk($sformatf("t%0d_fl", k),   32'(flush),         32'(tbl[k].mis));
            chk($sformatf("t%0d_bc", k),   32'(branch_cnt),    32'(tbl[k].b));
            chk($sformatf("t%0d_mc", k),   32'(mispred_cnt),   32'(tbl[k].m));
            chk($sformatf("t%0d_ovf", k),  32'(overflow_err),  32'(tbl[k].ovf));
            chk($sformatf("t%0d_unf", k),  32'(underflow_err), 32'(tbl[k].unf));
        end

        // Reset mid-operation with 3 entries and result held high.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 1, 1);
        step(1, 1, 0, 0);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        chk("pre_rst_res", 32'(result),    32'd1);
        @(negedge clk);
        rst = 1'b1; issue = 0; pred = 0; resolve_valid = 0; resolve_taken = 0;
        #1;
        check_reset("mid");
        model_reset();
        #2 rst = 1'b0;

        // Same as the first basic branch after reset.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        chk("post_rst_res", 32'(result),     32'd1);
        chk("post_rst_tk",  32'(taken),      32'd1);
        chk("post_rst_mis", 32'(mispredict), 32'd0);
        chk("post_rst_bc",  32'(branch_cnt), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
